// File: rtl/alu_accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_accum_sequencer
// Description : Command sequencer around an external adder/subtractor. It holds
//               the accumulator and the C/V/Z/N flags, and pulses done when a
//               command retires. Optional macro ALU_ACCUM_SATURATE_EN makes
//               signed overflow saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_accum_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c,
    input  logic             add_v,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             done
);

    localparam logic [1:0] C_OP_CLR  = 2'b00;
    localparam logic [1:0] C_OP_LOAD = 2'b01;
    localparam logic [1:0] C_OP_ADD  = 2'b10;
    localparam logic [1:0] C_OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_acc;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             w_accept;
    logic [WIDTH-1:0] w_arith;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_c_next;
    logic             w_v_next;

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign done      = (r_state == S_DONE);

    // The adder is driven from registers only, so its inputs are stable for the whole EXEC cycle.
    assign add_a  = r_acc;
    assign add_b  = r_operand;
    assign add_op = (r_op == C_OP_SUB);

    assign acc    = r_acc;
    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;
    assign flag_z = (r_acc == '0);
    assign flag_n = r_acc[WIDTH-1];

`ifdef ALU_ACCUM_SATURATE_EN
    // Overflow direction follows the sign of the accumulator before the operation.
    always_comb begin
        w_arith = add_s;
        if (add_v) begin
            w_arith = r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_arith = add_s;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_acc_next = '0;
        w_c_next   = 1'b0;
        w_v_next   = 1'b0;
        case (r_op)
            C_OP_CLR:  w_acc_next = '0;
            C_OP_LOAD: w_acc_next = r_operand;
            C_OP_ADD, C_OP_SUB: begin
                w_acc_next = w_arith;
                w_c_next   = add_c;
                w_v_next   = add_v;
            end
            default:   w_acc_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= C_OP_CLR;
            r_operand <= '0;
            r_acc     <= '0;
            r_flag_c  <= 1'b0;
            r_flag_v  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op      <= cmd_op;
                r_operand <= cmd_data;
            end
            if (r_state == S_EXEC) begin
                r_acc    <= w_acc_next;
                r_flag_c <= w_c_next;
                r_flag_v <= w_v_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_accum_sequencer
// Description : Scoreboard bench with a behavioural 16-bit adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accum_sequencer;

    localparam int W = 16;
    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] add_a, add_b, add_s, acc;
    logic         add_op, add_c, add_v;
    logic         flag_c, flag_v, flag_z, flag_n, done;

    alu_accum_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .add_a(add_a), .add_b(add_b), .add_op(add_op),
        .add_s(add_s), .add_c(add_c), .add_v(add_v),
        .acc(acc), .flag_c(flag_c), .flag_v(flag_v),
        .flag_z(flag_z), .flag_n(flag_n), .done(done)
    );

    always #5 clk = ~clk;

    // External adder: C is carry-out on add, borrow on subtract.
    always_comb begin
        logic [W:0] r;
        if (add_op) begin
            r     = {1'b0, add_a} - {1'b0, add_b};
            add_v = (add_a[W-1] != add_b[W-1]) && (r[W-1] != add_a[W-1]);
        end else begin
            r     = {1'b0, add_a} + {1'b0, add_b};
            add_v = (add_a[W-1] == add_b[W-1]) && (r[W-1] != add_a[W-1]);
        end
        add_s = r[W-1:0];
        add_c = r[W];
    end

    typedef struct packed {
        logic [W-1:0] acc;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    int   done_cyc[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cyc.push_back(cyc);
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("acc",    acc,    e.acc);
                check("flag_c", flag_c, e.c);
                check("flag_v", flag_v, e.v);
                check("flag_z", flag_z, (e.acc == '0));
                check("flag_n", flag_n, e.acc[W-1]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the block back in IDLE.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] d,
                         input logic [W-1:0] ea, input logic ec, input logic ev);
        int k;
        k = 0;
        while (!cmd_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("issue_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        q.push_back('{ea, ec, ev});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'hDEAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t stream_exp [3];
        int   k;
        stream_exp[0] = '{16'h00FF, 1'b1, 1'b0};
        stream_exp[1] = '{16'h0202, 1'b0, 1'b0};
        stream_exp[2] = '{16'h0308, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_acc",   acc,       16'h0000);
        check("rst_z",     flag_z,    1'b1);
        check("rst_c",     flag_c,    1'b0);
        check("rst_v",     flag_v,    1'b0);
        check("rst_n",     flag_n,    1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done",  done,      1'b0);

        // LOAD then ADD back to back; done pulses should be 3 cycles apart.
        issue(OP_LOAD, 16'h1234, 16'h1234, 1'b0, 1'b0);
        issue(OP_ADD,  16'h0001, 16'h1235, 1'b0, 1'b0);
        check("done_count", done_cyc.size(), 2);
        if (done_cyc.size() >= 2)
            check("done_spacing", done_cyc[1] - done_cyc[0], 3);

        issue(OP_LOAD, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
`ifdef ALU_ACCUM_SATURATE_EN
        issue(OP_ADD,  16'h0001, 16'h7FFF, 1'b0, 1'b1);
`else
        issue(OP_ADD,  16'h0001, 16'h8000, 1'b0, 1'b1);
`endif

        issue(OP_LOAD, 16'h0005, 16'h0005, 1'b0, 1'b0);
        issue(OP_SUB,  16'h0005, 16'h0000, 1'b0, 1'b0);
        issue(OP_SUB,  16'h0001, 16'hFFFF, 1'b1, 1'b0);

        // Continuous valid with changing data: only IDLE-cycle samples are taken.
        for (int i = 0; i < 7; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_ADD;
            cmd_data  = 16'h0100 + 16'(i);
            check("stream_ready", cmd_ready, (i % 3) == 0);
            check("stream_done",  done,      (i % 3) == 2);
            if ((i % 3) == 0) q.push_back(stream_exp[i / 3]);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during EXEC aborts the command with no done pulse.
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 16'h0010;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("abort_in_exec", cmd_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_acc",   acc,       16'h0000);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_done",  done,      1'b0);
        check("abort_z",     flag_z,    1'b1);
        @(posedge clk); #1;
        check("abort_done2", done, 1'b0);
        @(posedge clk); #1;
        check("abort_done3", done, 1'b0);

        // CLR must clear a previously set borrow.
        issue(OP_SUB, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        issue(OP_CLR, 16'h5555, 16'h0000, 1'b0, 1'b0);

        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
